simon_data_in: RTL and testbench
================================

Name: simon_data_in

Overview:
- Byte-serial frame receiver feeding the SIMON core. It is the input-side counterpart of the output serializer.
- Accepts one byte per transfer from the link-side receiver and assembles a frame: info byte, count byte, optional block, optional key.
- Presents the assembled fields in parallel to the core and holds them until the core acknowledges.
- Applies backpressure to the link while a frame is pending.

Parameters:
- N, 16, word size in bits; multiple of 8.
- M, 4, number of key words.
- T, 32, round count limit; a received count value must be < T.

Ports:
- clk  input  1  system clock, all logic on rising edge
- R  input  1  reset, synchronous, active-high
- byteIN  input  8  received byte
- byteValid  input  1  byteIN valid this cycle
- readyIN  output  1  block can accept a byte this cycle
- infoIN  output  8  frame info byte
- countIN  output  8  frame count byte
- blockIN  output  [1:0][N-1:0]  plaintext/ciphertext block
- KEY  output  [M-1:0][N-1:0]  key words
- newIN  output  1  complete frame available
- errIN  output  1  countIN >= T for the current frame
- readIN  input  1  core acknowledge of pending frame

Behaviour:
- Transfer rule: a byte is accepted only on a clk edge where byteValid && readyIN && !R.
- readyIN = (state != HOLD). Combinational from the state register.
- States: IDLE -> COUNT -> BLOCK -> KEY -> HOLD -> IDLE.
- IDLE:
  - Accepted byte loads infoIN; go to COUNT.
  - infoIN[7] = block present; infoIN[6] = key present; bits [5:0] pass through uninterpreted.
- COUNT:
  - Accepted byte loads countIN.
  - errIN <= (byte >= T), compared as 8-bit unsigned.
  - Next state: BLOCK if info[7]; else KEY if info[6]; else HOLD.
- BLOCK:
  - Receives 2N/8 bytes, least significant byte first, into the packed vector {blockIN[1],blockIN[0]}.
  - The first byte goes to blockIN[0][7:0].
  - After the last byte: KEY if info[6], else HOLD.
- KEY:
  - Receives M*N/8 bytes, LS byte first, into the packed KEY vector. The first byte goes to KEY[0][7:0].
  - After the last byte, go to HOLD.
- Byte counter:
  - Width clog2(M*N/8); cleared on entry to BLOCK and KEY.
  - Increments only on accepted bytes. Gaps in byteValid are tolerated with no timeout.
- Field writes are in-place per byte. Fields of absent sections keep their previous values, so the key persists across block-only frames.
- HOLD:
  - newIN = 1 from the cycle after the last accepted byte of the frame (1-cycle latency).
  - newIN stays high until readIN is sampled high. The next cycle is IDLE with newIN = 0.
  - Fields and errIN remain stable throughout HOLD and afterwards, until overwritten.
  - readIN outside HOLD is ignored.
- Simultaneous events:
  - readIN together with byteValid in HOLD: the byte is not accepted. readyIN stays 0 for that cycle and the byte must be re-presented.
  - R has priority over all other inputs.
- Reset (any time, including mid-frame):
  - State returns to IDLE; byte counter = 0.
  - infoIN, countIN, blockIN, KEY = 0; newIN = 0; errIN = 0.
  - readyIN = 1 once R deasserts; bytes are ignored while R = 1.
  - A partial frame is discarded. The next accepted byte is treated as an info byte.
- Width rule: N not a multiple of 8 is illegal (elaboration-time check).

Test Plan (N=16, M=4, T=32):
1. Full frame, byteValid continuous: C0, 05, 11 22 33 44, 01 02 03 04 05 06 07 08.
   - newIN = 1 one cycle after the 14th byte; readyIN = 0.
   - countIN = 05; errIN = 0.
   - blockIN[0] = 16'h2211; blockIN[1] = 16'h4433.
   - KEY[0] = 16'h0201; KEY[3] = 16'h0807.
2. Backpressure: after frame 1 completes, hold byteValid = 1 with byte AA for 5 cycles, then pulse readIN.
   - AA is not accepted during HOLD; newIN drops the cycle after readIN.
   - AA is accepted next and infoIN = AA.
3. Block-only frame after frame 1: 80, 06, 55 66 77 88.
   - blockIN[0] = 16'h6655; blockIN[1] = 16'h8877.
   - KEY is unchanged (KEY[0] = 16'h0201).
   - newIN after the 6th byte.
4. Header-only frame: 00, 20.
   - newIN one cycle after the 2nd byte; errIN = 1; block and key unchanged.
   - Follow with 00, 1F: errIN = 0.
5. Reset mid-frame: assert R for one cycle after 3 block bytes.
   - All outputs are 0 and readyIN = 1 after R deasserts.
   - A subsequent full frame assembles correctly, matching scenario 1.
6. Gapped input: scenario 1 bytes with byteValid low for 1–3 random cycles between bytes.
   - Identical field values to scenario 1; newIN one cycle after the last byte is accepted.

Source files
------------

// File: rtl/simon_data_in.sv
// Byte-serial frame receiver for the SIMON core.
// Assembles info/count/block/key fields and holds them until acknowledged.
module simon_data_in #(
  parameter int          N = 16,
  parameter int          M = 4,
  parameter int unsigned T = 32
) (
  input  logic                clk,
  input  logic                R,
  input  logic [7:0]          byteIN,
  input  logic                byteValid,
  output logic                readyIN,
  output logic [7:0]          infoIN,
  output logic [7:0]          countIN,
  output logic [1:0][N-1:0]   blockIN,
  output logic [M-1:0][N-1:0] KEY,
  output logic                newIN,
  output logic                errIN,
  input  logic                readIN
);

  localparam int BB = 2 * N / 8;
  localparam int KB = M * N / 8;
  localparam int MB = (BB > KB) ? BB : KB;
  localparam int CW = $clog2(MB);

  generate
    if (N % 8 != 0) begin : g_bad_n
      $error("simon_data_in: N must be a multiple of 8");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_BLOCK,
    S_KEY,
    S_HOLD
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [7:0]       r_info;
  logic [7:0]       r_count;
  logic [2*N-1:0]   r_block;
  logic [M*N-1:0]   r_key;
  logic             r_new;
  logic             r_err;
  logic             w_take;
  logic             w_blast;
  logic             w_klast;

  assign readyIN = (r_state != S_HOLD);
  assign w_take  = byteValid && readyIN;
  assign w_blast = (r_cnt == CW'(BB - 1));
  assign w_klast = (r_cnt == CW'(KB - 1));

  assign infoIN  = r_info;
  assign countIN = r_count;
  assign blockIN = r_block;
  assign KEY     = r_key;
  assign newIN   = r_new;
  assign errIN   = r_err;

  always_ff @(posedge clk) begin
    if (R) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_info  <= '0;
      r_count <= '0;
      r_block <= '0;
      r_key   <= '0;
      r_new   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_info  <= byteIN;
            r_state <= S_COUNT;
          end
        end
        S_COUNT: begin
          if (w_take) begin
            r_count <= byteIN;
            r_err   <= (32'(byteIN) >= T);
            r_cnt   <= '0;
            if (r_info[7]) begin
              r_state <= S_BLOCK;
            end else if (r_info[6]) begin
              r_state <= S_KEY;
            end else begin
              r_state <= S_HOLD;
              r_new   <= 1'b1;
            end
          end
        end
        S_BLOCK: begin
          if (w_take) begin
            // Byte slots decoded against the counter keep indices constant.
            for (int b = 0; b < BB; b++) begin
              if (r_cnt == CW'(b)) r_block[b*8 +: 8] <= byteIN;
            end
            if (w_blast) begin
              r_cnt <= '0;
              if (r_info[6]) begin
                r_state <= S_KEY;
              end else begin
                r_state <= S_HOLD;
                r_new   <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_KEY: begin
          if (w_take) begin
            for (int b = 0; b < KB; b++) begin
              if (r_cnt == CW'(b)) r_key[b*8 +: 8] <= byteIN;
            end
            if (w_klast) begin
              r_cnt   <= '0;
              r_state <= S_HOLD;
              r_new   <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (readIN) begin
            r_new   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_data_in.sv
// Testbench for simon_data_in: frame-level model plus directed scenarios.
// Compares every output on each falling edge and pins key values by hand.
module tb_simon_data_in;

  localparam int N  = 16;
  localparam int M  = 4;
  localparam int T  = 32;
  localparam int BB = 2 * N / 8;
  localparam int KB = M * N / 8;

  logic                clk = 1'b0;
  logic                R;
  logic [7:0]          byteIN;
  logic                byteValid;
  logic                readyIN;
  logic [7:0]          infoIN;
  logic [7:0]          countIN;
  logic [1:0][N-1:0]   blockIN;
  logic [M-1:0][N-1:0] KEY;
  logic                newIN;
  logic                errIN;
  logic                readIN;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  simon_data_in #(.N(N), .M(M), .T(T)) dut (
    .clk      (clk),
    .R        (R),
    .byteIN   (byteIN),
    .byteValid(byteValid),
    .readyIN  (readyIN),
    .infoIN   (infoIN),
    .countIN  (countIN),
    .blockIN  (blockIN),
    .KEY      (KEY),
    .newIN    (newIN),
    .errIN    (errIN),
    .readIN   (readIN)
  );

  always #5 clk = ~clk;

  // Frame model: position within frame decides where each byte lands.
  int             m_pos;
  bit             m_pend;
  bit             m_err;
  logic [7:0]     m_info;
  logic [7:0]     m_count;
  logic [2*N-1:0] m_blk;
  logic [M*N-1:0] m_key;

  initial begin
    m_pos = 0; m_pend = 0; m_err = 0;
    m_info = '0; m_count = '0; m_blk = '0; m_key = '0;
    forever begin
      @(posedge clk);
      if (R) begin
        m_pos = 0; m_pend = 0; m_err = 0;
        m_info = '0; m_count = '0; m_blk = '0; m_key = '0;
      end else if (m_pend) begin
        if (readIN) m_pend = 0;
      end else if (byteValid) begin
        int k;
        int flen;
        if (m_pos == 0) begin
          m_info = byteIN;
        end else if (m_pos == 1) begin
          m_count = byteIN;
          m_err   = (byteIN >= T);
        end else begin
          k = m_pos - 2;
          if (m_info[7] && k < BB) m_blk[k*8 +: 8] = byteIN;
          else m_key[(k - (m_info[7] ? BB : 0))*8 +: 8] = byteIN;
        end
        m_pos++;
        flen = 2 + (m_info[7] ? BB : 0) + (m_info[6] ? KB : 0);
        if (m_pos == flen) begin
          m_pend = 1;
          m_pos  = 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_ready", 128'(readyIN), 128'(!m_pend));
      chk("m_new", 128'(newIN), 128'(m_pend));
      chk("m_err", 128'(errIN), 128'(m_err));
      chk("m_info", 128'(infoIN), 128'(m_info));
      chk("m_count", 128'(countIN), 128'(m_count));
      chk("m_block", 128'({blockIN[1], blockIN[0]}), 128'(m_blk));
      chk("m_key", 128'(KEY), 128'(m_key));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    byteIN    = b;
    byteValid = 1'b1;
    while (!acc && n < 50) begin
      acc = readyIN;
      step();
      n++;
    end
    byteValid = 1'b0;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: byte %0h not accepted in %0d cycles", b, n);
    end
  endtask

  task automatic ack();
    readIN = 1'b1;
    step();
    readIN = 1'b0;
  endtask

  task automatic pulse_reset();
    R = 1'b1;
    step();
    R = 1'b0;
  endtask

  logic [7:0] f1 [14] = '{8'hC0, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44,
                          8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                          8'h07, 8'h08};

  task automatic pin_frame1(input string tag);
    chk({tag, "_new"}, 128'(newIN), 128'(1));
    chk({tag, "_ready"}, 128'(readyIN), 128'(0));
    chk({tag, "_count"}, 128'(countIN), 128'(8'h05));
    chk({tag, "_err"}, 128'(errIN), 128'(0));
    chk({tag, "_blk0"}, 128'(blockIN[0]), 128'(16'h2211));
    chk({tag, "_blk1"}, 128'(blockIN[1]), 128'(16'h4433));
    chk({tag, "_key0"}, 128'(KEY[0]), 128'(16'h0201));
    chk({tag, "_key3"}, 128'(KEY[3]), 128'(16'h0807));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    R = 1'b1; byteIN = '0; byteValid = 1'b0; readIN = 1'b0;
    step();
    step();
    R = 1'b0;
    chk_en = 1;
    chk("rst_ready", 128'(readyIN), 128'(1));
    chk("rst_new", 128'(newIN), 128'(0));

    // Full frame, continuous.
    foreach (f1[i]) send(f1[i]);
    pin_frame1("f1");

    // Backpressure: AA held while pending, accepted after ack.
    byteIN = 8'hAA;
    byteValid = 1'b1;
    repeat (5) step();
    chk("bp_info_hold", 128'(infoIN), 128'(8'hC0));
    readIN = 1'b1;
    step();
    readIN = 1'b0;
    chk("bp_new_drop", 128'(newIN), 128'(0));
    chk("bp_info_still", 128'(infoIN), 128'(8'hC0));
    send(8'hAA);
    chk("bp_info_aa", 128'(infoIN), 128'(8'hAA));
    send(8'h06);
    send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    chk("bp_blk0", 128'(blockIN[0]), 128'(16'h3412));
    chk("bp_blk1", 128'(blockIN[1]), 128'(16'h7856));
    ack();

    // Block-only frame keeps the key.
    send(8'h80); send(8'h06);
    send(8'h55); send(8'h66); send(8'h77); send(8'h88);
    chk("b_new", 128'(newIN), 128'(1));
    chk("b_blk0", 128'(blockIN[0]), 128'(16'h6655));
    chk("b_blk1", 128'(blockIN[1]), 128'(16'h8877));
    chk("b_key0", 128'(KEY[0]), 128'(16'h0201));
    ack();

    // Header-only frames: count boundary at T.
    send(8'h00); send(8'h20);
    chk("h_new", 128'(newIN), 128'(1));
    chk("h_err1", 128'(errIN), 128'(1));
    chk("h_blk0", 128'(blockIN[0]), 128'(16'h6655));
    ack();
    chk("h_err_stable", 128'(errIN), 128'(1));
    send(8'h00); send(8'h1F);
    chk("h_err0", 128'(errIN), 128'(0));
    ack();

    // Reset mid-frame.
    for (int i = 0; i < 5; i++) send(f1[i]);
    pulse_reset();
    chk("r_ready", 128'(readyIN), 128'(1));
    chk("r_info", 128'(infoIN), 128'(0));
    chk("r_blk", 128'({blockIN[1], blockIN[0]}), 128'(0));
    chk("r_key", 128'(KEY), 128'(0));
    foreach (f1[i]) send(f1[i]);
    pin_frame1("r_f1");
    ack();

    // Gapped input.
    foreach (f1[i]) begin
      repeat ($urandom_range(1, 3)) step();
      send(f1[i]);
    end
    pin_frame1("g_f1");
    ack();
    step();

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
